// File: rtl/uart_rx_mmio.sv
// uart_rx_mmio
// Memory-mapped UART receiver (8N1, LSB first). It deserializes rxd into a
// byte FIFO and exposes four word registers to CPU loads and stores.
// Bus read data is combinational. Pops, W1C clears and register writes
// take effect at the rising clock edge.
//
// Ports
//   clk    system clock, rising edge
//   n_rst  synchronous, active-low reset
//   cs_n   chip select, active low
//   re     read strobe, qualified by !cs_n; a read of RXDATA pops the FIFO
//   we     write strobe, qualified by !cs_n
//   addr   word index: 0=RXDATA 1=STATUS 2=CTRL 3=BAUDDIV
//   wbe    byte write enables
//   wdata  write data
//   rdata  read data, combinational, 0 while cs_n=1
//   rxd    asynchronous serial input
//   irq    level interrupt, registered
//
// Register map
//   RXDATA  [7:0] FIFO head, [31] not_empty
//   STATUS  [0] not_empty, [1] full, [2] overrun (W1C), [3] ferr (W1C),
//           [4] perr (W1C, parity build only), [15:8] count
//   CTRL    [0] en, [1] irq_en, [2] par_en (parity build only)
//   BAUDDIV [CNT_W-1:0] clocks per bit minus one
//
// Optional feature macro: UART_RX_PARITY_EN
//   When defined, an even-parity bit is expected between the data bits and
//   the stop bit. The check is gated by CTRL.par_en.

module uart_rx_mmio #(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        cs_n,
    input  logic        re,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  wbe,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        rxd,
    output logic        irq
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] BAUD_RST = CNT_W'(CLOCK_FREQ / BAUD_RATE - 1);

    localparam logic [1:0] A_RXDATA = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_BAUD   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Merge the bytes of a write into the baud divider, honouring the byte enables.
    function automatic logic [CNT_W-1:0] merge_bytes(
        input logic [CNT_W-1:0] cur,
        input logic [31:0]      d,
        input logic [3:0]       be
    );
        logic [CNT_W-1:0] r;
        r = cur;
        for (int i = 0; i < CNT_W; i++) begin
            if (i < 32 && be[i/8]) r[i] = d[i];
        end
        return r;
    endfunction

    // Control and status registers
    logic             en;
    logic             irq_en;
    logic [CNT_W-1:0] baud_div;
    logic             ovr;
    logic             ferr;
    logic             perr;
    logic             par_en;

    // Receiver state
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic             par_bad;

    // Line synchronizer
    logic sync1;
    logic line;
    logic line_d;
    logic fall;

    // FIFO
    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count;
    logic [7:0]  count8;
    logic        not_empty;
    logic        full;

    // Bus decode and events
    logic rd_acc;
    logic wr_acc;
    logic wr_status;
    logic wr_ctrl;
    logic wr_baud;
    logic pop;
    logic stop_hit;
    logic push;
    logic ovr_set;
    logic ferr_set;
    logic perr_set;

    assign rd_acc    = !cs_n && re;
    assign wr_acc    = !cs_n && we;
    assign wr_status = wr_acc && (addr == A_STATUS) && wbe[0];
    assign wr_ctrl   = wr_acc && (addr == A_CTRL) && wbe[0];
    assign wr_baud   = wr_acc && (addr == A_BAUD);

    assign count     = wptr - rptr;
    assign count8    = 8'(count);
    assign not_empty = (count != '0);
    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign pop       = rd_acc && (addr == A_RXDATA) && not_empty;

    assign fall = line_d && !line;

    // A stop bit is judged only while enabled; clearing en aborts the frame.
    assign stop_hit = en && (state == S_STOP) && (cnt == '0);
    // A full FIFO still accepts the byte when the head leaves in the same cycle.
    assign push     = stop_hit && line && !par_bad && (!full || pop);
    assign ovr_set  = stop_hit && line && !par_bad && full && !pop;
    assign ferr_set = stop_hit && !line;

`ifdef UART_RX_PARITY_EN
    assign perr_set = en && (state == S_PARITY) && (cnt == '0) && (line != ^shreg);
`else
    assign perr_set = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sync1  <= 1'b1;
            line   <= 1'b1;
            line_d <= 1'b1;
        end else begin
            sync1  <= rxd;
            line   <= sync1;
            line_d <= line;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            idx     <= '0;
            par_bad <= 1'b0;
        end else if (!en) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (fall) begin
                        cnt   <= baud_div >> 1;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (!line) begin
                        cnt     <= baud_div;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        state   <= S_DATA;
                    end else begin
                        // Start bit no longer low at mid-bit: treat as a glitch.
                        state <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        shreg[idx] <= line;
                        cnt        <= baud_div;
                        if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= par_en ? S_PARITY : S_STOP;
`else
                            state <= S_STOP;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        par_bad <= (line != ^shreg);
                        cnt     <= baud_div;
                        state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= shreg;
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            en       <= 1'b1;
            irq_en   <= 1'b0;
            baud_div <= BAUD_RST;
            ovr      <= 1'b0;
            ferr     <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            irq      <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            // A set in the same cycle as a clear wins.
            if (ovr_set)                    ovr <= 1'b1;
            else if (wr_status && wdata[2]) ovr <= 1'b0;
            if (ferr_set)                    ferr <= 1'b1;
            else if (wr_status && wdata[3])  ferr <= 1'b0;

            if (wr_ctrl) begin
                en     <= wdata[0];
                irq_en <= wdata[1];
            end
            if (wr_baud) baud_div <= merge_bytes(baud_div, wdata, wbe);

            irq <= irq_en && (not_empty || ovr || ferr || perr);
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            perr   <= 1'b0;
            par_en <= 1'b1;
        end else begin
            if (perr_set)                   perr <= 1'b1;
            else if (wr_status && wdata[4]) perr <= 1'b0;
            if (wr_ctrl) par_en <= wdata[2];
        end
    end
`else
    assign perr   = perr_set;
    assign par_en = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (!cs_n) begin
            case (addr)
                A_RXDATA: if (not_empty) rdata = {1'b1, 23'd0, mem[rptr[AW-1:0]]};
                A_STATUS: rdata = {16'd0, count8, 3'd0, perr, ferr, ovr, full, not_empty};
                A_CTRL:   rdata = {29'd0, par_en, irq_en, en};
                default:  rdata[CNT_W-1:0] = baud_div;
            endcase
        end
    end

endmodule
